// File: rtl/div_sched.sv
// Round-robin front end that time-shares one sequential divider core among NREQ requesters.
// Handles divide-by-zero without starting the core and aborts a job whose core never answers.
module div_sched #(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int TMO  = 64,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q_out,
  output logic [W-1:0]      r_out,
  output logic              err,
  output logic              busy,
  output logic [IW-1:0]     gnt_id,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  output logic              div_init,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r,
  input  logic              div_done
);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP, S_DRAIN} state_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } res_t;

  state_t        st_q, st_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  res_t          res_q, res_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          started_q, started_d;

  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_sel, b_sel;

  // Search ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign a_sel = a_in[int'(win_id)*W +: W];
  assign b_sel = b_in[int'(win_id)*W +: W];

  always_comb begin
    st_d      = st_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    wdog_d    = wdog_q;
    started_d = started_q;
    case (st_q)
      S_IDLE: begin
        if (win_vld) begin
          ptr_d = win_id;
          gnt_d = win_id;
          a_d   = a_sel;
          b_d   = b_sel;
          if (b_sel == '0) begin
            res_d     = '{q: {W{1'b1}}, r: a_sel, err: 1'b1};
            started_d = 1'b0;
            st_d      = S_RESP;
          end else begin
            started_d = 1'b1;
            st_d      = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        wdog_d = '0;
        st_d   = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + TW'(1);
        if (div_done) begin
          res_d = '{q: div_q, r: div_r, err: 1'b0};
          st_d  = S_RESP;
        end else if (wdog_q == TW'(TMO - 1)) begin
          res_d = '{q: '0, r: '0, err: 1'b1};
          st_d  = S_RESP;
        end
      end
      S_RESP:  st_d = started_q ? S_DRAIN : S_IDLE;
      // A level-style done may still be high; never start the next job on a stale done.
      S_DRAIN: if (!div_done) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      wdog_q    <= '0;
      started_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      wdog_q    <= wdog_d;
      started_q <= started_d;
    end
  end

  assign ack      = (st_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign q_out    = res_q.q;
  assign r_out    = res_q.r;
  assign err      = res_q.err;
  assign busy     = (st_q != S_IDLE);
  assign gnt_id   = gnt_q;
  assign div_a    = a_q;
  assign div_b    = b_q;
  assign div_init = (st_q == S_LOAD) || (st_q == S_WAIT);
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: a latency/round-robin job model checks every cycle,
// literal expectations pin the model on each scenario.
module tb_div_sched;
  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int TMO  = 64;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q_out, r_out, div_a, div_b, div_q, div_r;
  logic              err, busy, div_init, div_done;
  logic [IW-1:0]     gnt_id;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*W +: W] = a_arr[i];
      b_in[i*W +: W] = b_arr[i];
    end
  end

  div_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .q_out(q_out), .r_out(r_out), .err(err), .busy(busy),
    .gnt_id(gnt_id), .div_a(div_a), .div_b(div_b), .div_init(div_init),
    .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider core: answers lat cycles after start, level (lingers 2 cycles) or pulse done.
  int   lat = 0;
  bit   level = 1'b0;
  bit   hang = 1'b0;
  int   cnt = 0;
  int   linger = 0;
  logic core_done = 1'b0;
  logic [W-1:0] core_q = '0, core_r = '0;
  assign div_done = core_done;
  assign div_q    = core_q;
  assign div_r    = core_r;

  always @(posedge clk) begin
    if (!div_init) begin
      cnt <= 0;
      if (linger > 0) linger <= linger - 1;
      else core_done <= 1'b0;
    end else begin
      if (cnt < 1000) cnt <= cnt + 1;
      if (!hang && cnt == lat) begin
        core_done <= 1'b1;
        core_q    <= (div_b != 0) ? div_a / div_b : '1;
        core_r    <= (div_b != 0) ? div_a % div_b : '0;
        linger    <= level ? 2 : 0;
      end else if (!level) core_done <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int id; int q; int r; int err; int cyc;} ev_t;
  ev_t log_q[$];

  // Job model: one outstanding job, timing derived from the core configuration.
  bit m_valid = 1'b0;
  bit m_started;
  int m_ptr = NREQ - 1;
  int m_gcyc, m_ack, m_idle = 0;
  int m_id, m_q, m_r, m_err;

  always @(negedge clk) begin
    int e_ack;
    bit e_busy, e_init;
    if (cyc > 0) begin
      if (m_valid && cyc >= m_idle) m_valid = 1'b0;
      e_ack  = (m_valid && cyc == m_ack) ? (1 << m_id) : 0;
      e_busy = m_valid && cyc > m_gcyc;
      e_init = m_valid && m_started && cyc > m_gcyc && cyc < m_ack;
      chk("ack", int'(ack), e_ack);
      chk("busy", int'(busy), int'(e_busy));
      chk("div_init", int'(div_init), int'(e_init));
      if (e_ack != 0) begin
        chk("q_out", int'(q_out), m_q);
        chk("r_out", int'(r_out), m_r);
        chk("err", int'(err), m_err);
        chk("gnt_id", int'(gnt_id), m_id);
      end
      if (ack != 0)
        log_q.push_back('{id: $clog2(int'(ack)), q: int'(q_out), r: int'(r_out),
                          err: int'(err), cyc: cyc});
      if (rst) begin
        m_valid = 1'b0;
        m_ptr   = NREQ - 1;
        m_idle  = cyc + 1;
      end else if (!m_valid && cyc >= m_idle && req != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int id;
          id = (m_ptr + k) % NREQ;
          if (req[id]) begin
            m_id = id;
            break;
          end
        end
        m_ptr   = m_id;
        m_valid = 1'b1;
        m_gcyc  = cyc;
        if (b_arr[m_id] == 0) begin
          m_q = 7; m_r = int'(a_arr[m_id]); m_err = 1; m_started = 1'b0;
          m_ack = cyc + 1; m_idle = cyc + 2;
        end else if (hang) begin
          m_q = 0; m_r = 0; m_err = 1; m_started = 1'b1;
          m_ack = cyc + TMO + 2; m_idle = m_ack + 2;
        end else begin
          m_q = int'(a_arr[m_id]) / int'(b_arr[m_id]);
          m_r = int'(a_arr[m_id]) % int'(b_arr[m_id]);
          m_err = 0; m_started = 1'b1;
          m_ack = cyc + 3 + lat; m_idle = m_ack + (level ? 4 : 2);
        end
      end
    end
  end

  task automatic wait_acks(int n, int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (log_q.size() < n) chk("ack_wait_expired", log_q.size(), n);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_q"}, int'(q_out), 0);
    chk({tag, "_r"}, int'(r_out), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_gnt"}, int'(gnt_id), 0);
    chk({tag, "_da"}, int'(div_a), 0);
    chk({tag, "_db"}, int'(div_b), 0);
    chk({tag, "_init"}, int'(div_init), 0);
  endtask

  initial begin
    int c0, base;
    ev_t ev;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    idle(3);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Round robin from reset: all 6/3, pulse-style core
    lat = 1; level = 1'b0; hang = 1'b0;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = 3'd6; b_arr[i] = 3'd3; end
    base = log_q.size();
    req = 4'b1111;
    wait_acks(base + 5, 200);
    #1 req = '0;
    for (int j = 0; j < 5 && base + j < log_q.size(); j++) begin
      ev = log_q[base + j];
      chk("rr_id", ev.id, j % NREQ);
      chk("rr_q", ev.q, 2);
      chk("rr_r", ev.r, 0);
    end
    idle(6);

    // Single job 7/2, level-style core
    lat = 2; level = 1'b1;
    a_arr[0] = 3'd7; b_arr[0] = 3'd2;
    base = log_q.size();
    req = 4'b0001; c0 = cyc;
    wait_acks(base + 1, 100);
    #1 req = '0;
    if (log_q.size() > base) begin
      ev = log_q[base];
      chk("single_id", ev.id, 0);
      chk("single_q", ev.q, 3);
      chk("single_r", ev.r, 1);
      chk("single_err", ev.err, 0);
      chk("single_lat", ev.cyc - c0, 5);
    end
    idle(6);
    @(negedge clk);
    chk("single_busy_after", int'(busy), 0);
    @(posedge clk); #1;

    // Divide by zero
    a_arr[2] = 3'd5; b_arr[2] = 3'd0;
    base = log_q.size();
    req = 4'b0100; c0 = cyc;
    wait_acks(base + 1, 20);
    #1 req = '0;
    if (log_q.size() > base) begin
      ev = log_q[base];
      chk("dz_id", ev.id, 2);
      chk("dz_q", ev.q, 7);
      chk("dz_r", ev.r, 5);
      chk("dz_err", ev.err, 1);
      chk("dz_lat", ev.cyc - c0, 1);
    end
    idle(4);

    // Timeout: core never answers
    hang = 1'b1; level = 1'b0;
    a_arr[3] = 3'd5; b_arr[3] = 3'd1;
    base = log_q.size();
    req = 4'b1000; c0 = cyc;
    wait_acks(base + 1, TMO + 40);
    #1 req = '0;
    if (log_q.size() > base) begin
      ev = log_q[base];
      chk("tmo_id", ev.id, 3);
      chk("tmo_q", ev.q, 0);
      chk("tmo_r", ev.r, 0);
      chk("tmo_err", ev.err, 1);
      chk("tmo_lat", ev.cyc - (c0 + 1), TMO + 1);
    end
    idle(5);

    // Reset while waiting on a hung core
    a_arr[0] = 3'd7; b_arr[0] = 3'd1;
    a_arr[1] = 3'd4; b_arr[1] = 3'd3;
    base = log_q.size();
    req = 4'b0001;
    idle(4);
    rst = 1'b1; req = '0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0; hang = 1'b0; lat = 3;
    req = 4'b0010;
    wait_acks(base + 1, 100);
    #1 req = '0;
    chk("midrst_acks", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      ev = log_q[base];
      chk("midrst_id", ev.id, 1);
      chk("midrst_q", ev.q, 1);
      chk("midrst_r", ev.r, 1);
      chk("midrst_err", ev.err, 0);
    end
    idle(6);

    // Operands and req change during WAIT are ignored
    lat = 4; level = 1'b1;
    a_arr[2] = 3'd6; b_arr[2] = 3'd4;
    base = log_q.size();
    req = 4'b0100; c0 = cyc;
    idle(3);
    a_arr[2] = 3'd7; b_arr[2] = 3'd1; req = '0;
    wait_acks(base + 1, 100);
    if (log_q.size() > base) begin
      ev = log_q[base];
      chk("stab_id", ev.id, 2);
      chk("stab_q", ev.q, 1);
      chk("stab_r", ev.r, 2);
      chk("stab_lat", ev.cyc - c0, 7);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
